// File: rtl/ex_mul_unit.sv
// rtl/ex_mul_unit.sv - iterative 32x32 shift-add multiplier with pipeline stall and flush
module ex_mul_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        signedOp,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        neg;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] addend;
    logic [63:0] result;

    // Signed requests work on magnitudes; 0x80000000 maps onto itself and is read as unsigned
    assign a_mag  = (signedOp && A[31]) ? (~A + 32'd1) : A;
    assign b_mag  = (signedOp && B[31]) ? (~B + 32'd1) : B;

    // Partial product for the multiplier bit selected by the iteration count
    assign addend = b_reg[count[4:0]] ? ({32'd0, a_reg} << count[4:0]) : 64'd0;

    // Final product with the result sign applied
    assign result = neg ? (~acc + 64'd1) : acc;

    // Control FSM, datapath registers and result registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= 6'd0;
            acc   <= 64'd0;
            a_reg <= 32'd0;
            b_reg <= 32'd0;
            neg   <= 1'b0;
            Hi    <= 32'd0;
            Lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        neg   <= signedOp & (A[31] ^ B[31]);
                        count <= 6'd0;
                        acc   <= 64'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc + addend;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= result;
                        Hi    <= result[63:32];
                        Lo    <= result[31:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    // ID/EX still holds the same mul here, so start is ignored
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN) || (state == SIGN);
    assign done  = (state == DONE);
    assign stall = !Reset && (((state == IDLE) && start && !flush) || busy);

endmodule

// File: tb/tb_ex_mul_unit.sv
// tb/tb_ex_mul_unit.sv - self-checking bench for ex_mul_unit
module tb_ex_mul_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        signedOp;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    ex_mul_unit dut (
        .clk      (clk),
        .Reset    (Reset),
        .start    (start),
        .signedOp (signedOp),
        .flush    (flush),
        .A        (A),
        .B        (B),
        .Hi       (Hi),
        .Lo       (Lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Issue one multiply at cycle 0 and check every cycle through 35
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit hold, input bit scramble, input string name);
        logic [63:0] p;
        logic        e_done;
        logic        e_stall;
        p = ref_prod(a, b, s);
        @(posedge clk); #1;
        A = a; B = b; signedOp = s; start = 1'b1; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s c0 stall/busy/done got %b%b%b want 100", name, stall, busy, done);
        end
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (!hold || c == 35) start = 1'b0;
            if (scramble) begin
                A = $urandom; B = $urandom; signedOp = 1'($urandom);
            end
            @(negedge clk);
            e_done  = (c == 34);
            e_stall = (c <= 33);
            if (c == 34) begin
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            checks++;
            if (done !== e_done || stall !== e_stall || busy !== e_stall) begin
                errors++;
                $display("FAIL %s c%0d done/stall/busy got %b%b%b want %b%b%b",
                         name, c, done, stall, busy, e_done, e_stall, e_stall);
            end
            checks++;
            if (Hi !== exp_hi || Lo !== exp_lo) begin
                errors++;
                $display("FAIL %s c%0d hi_lo got %h_%h want %h_%h", name, c, Hi, Lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b1; flush = 1'b0; signedOp = 1'b0; A = 32'd7; B = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset hi=%h lo=%h busy=%b done=%b stall=%b want all zero", Hi, Lo, busy, done, stall);
        end
        @(posedge clk); #1;
        Reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b stall=%b want 0 0", busy, stall);
        end
    endtask

    task automatic test_unsigned_basic();
        run_mul(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, "u_3x5");
    endtask

    task automatic test_signed_cases();
        run_mul(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0, "s_m2x3");
        run_mul(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, "s_min_sq");
        run_mul(32'd7, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0, "s_7xm7");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "s_m1xm1");
    endtask

    task automatic test_unsigned_max();
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "u_max");
        run_mul(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, "u_msb_sq");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_mul($urandom, $urandom, 1'($urandom), 1'b0, 1'b0, "rand");
        end
    endtask

    task automatic test_operand_change();
        run_mul($urandom, $urandom, 1'b1, 1'b0, 1'b1, "scramble_s");
        run_mul($urandom, $urandom, 1'b0, 1'b0, 1'b1, "scramble_u");
    endtask

    task automatic test_flush();
        run_mul(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, "pre_flush");
        @(posedge clk); #1;
        A = 32'd7; B = 32'd9; signedOp = 1'b0; start = 1'b1; flush = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = (c == 10);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd15) begin
                errors++;
                $display("FAIL flush c%0d done=%b hi_lo=%h_%h want 0 0_f", c, done, Hi, Lo);
            end
            if (c == 10 || c == 11) begin
                checks++;
                if (stall !== (c == 10) || busy !== (c == 10)) begin
                    errors++;
                    $display("FAIL flush_state c%0d stall=%b busy=%b want %b", c, stall, busy, (c == 10));
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_flush_idle();
        @(posedge clk); #1;
        A = 32'd4; B = 32'd4; signedOp = 1'b0; start = 1'b1; flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL flush_idle c%0d stall=%b busy=%b want 0 0", c, stall, busy);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
            errors++;
            $display("FAIL flush_idle_after busy=%b hi_lo=%h_%h want 0 %h_%h", busy, Hi, Lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        A = 32'd123; B = 32'd456; signedOp = 1'b0; start = 1'b1; flush = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #2;
        start = 1'b1;
        Reset = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid hi=%h lo=%h busy=%b stall=%b done=%b want all zero",
                     Hi, Lo, busy, stall, done);
        end
        @(posedge clk); #1;
        Reset = 1'b0; start = 1'b0;
        run_mul(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, "after_reset_2x2");
    endtask

    task automatic test_start_held();
        run_mul(32'd11, 32'd13, 1'b0, 1'b1, 1'b0, "start_held");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_held_tail c%0d busy=%b done=%b want 0 0", c, busy, done);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_cases();
        test_unsigned_max();
        test_random();
        test_operand_change();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
